// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan driver (ports: clk, rst_n, thou/hund/ten/one, load, dp, blink_mask, blank_lz -> an, seg, dp_out, frame_tick)
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int DEAD      = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] thou,
  input  logic [3:0] hund,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  input  logic       load,
  input  logic [3:0] dp,
  input  logic [3:0] blink_mask,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_out,
  output logic       frame_tick
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [15:0]   r_sh;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink;
  logic          r_boff;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_ft;
  logic [3:0]    w_d;
  logic [6:0]    w_pat;
  logic          w_last, w_btc, w_blank, w_dark;
  assign w_last  = r_slot == SW'(SCAN_DIV - 1);
  assign w_btc   = r_blink == BW'(BLINK_DIV - 1);
  assign w_d     = r_sh[{r_idx, 2'b00} +: 4];
  assign w_blank = blank_lz & (r_idx == 2'd3 ? r_sh[15:12] == 4'h0 :
                               r_idx == 2'd2 ? r_sh[15:8] == 8'h0 :
                               r_idx == 2'd1 ? r_sh[15:4] == 12'h0 : 1'b0);
  assign w_dark  = (32'(r_slot) < DEAD) | (r_boff & blink_mask[r_idx]);
  always_comb begin
    w_pat = 7'b0111111;
    case (w_d)
      4'd0: w_pat = 7'b1000000;
      4'd1: w_pat = 7'b1111001;
      4'd2: w_pat = 7'b0100100;
      4'd3: w_pat = 7'b0110000;
      4'd4: w_pat = 7'b0011001;
      4'd5: w_pat = 7'b0010010;
      4'd6: w_pat = 7'b0000010;
      4'd7: w_pat = 7'b1111000;
      4'd8: w_pat = 7'b0000000;
      4'd9: w_pat = 7'b0010000;
      default: w_pat = 7'b0111111;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_slot  <= '0;
      r_idx   <= '0;
      r_blink <= '0;
      r_boff  <= 1'b0;
      r_an    <= 4'hf;
      r_seg   <= 7'h7f;
      r_dp    <= 1'b1;
      r_ft    <= 1'b0;
    end else begin
      if (load) r_sh <= {thou, hund, ten, one};
      r_slot  <= w_last ? '0 : r_slot + 1'b1;
      if (w_last) r_idx <= r_idx + 1'b1;
      r_blink <= w_btc ? '0 : r_blink + 1'b1;
      if (w_btc) r_boff <= ~r_boff;
      r_ft    <= w_last & (r_idx == 2'd3);
      r_an    <= w_dark ? 4'hf : ~(4'b1 << r_idx);
      r_seg   <= (w_dark | w_blank) ? 7'h7f : w_pat;
      r_dp    <= w_dark | ~dp[r_idx];
    end
  end
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_out     = r_dp;
  assign frame_tick = r_ft;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized check of seg7_scan_driver against an arithmetic reference model
module tb_seg7_scan_driver;
  localparam int SD = 4, DL = 1, BD = 32;
  logic clk = 0, rst_n = 0, load = 0, blank_lz = 0;
  logic [3:0] thou = 0, hund = 0, ten = 0, one = 0, dp = 0, blink_mask = 0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp_out, frame_tick;
  int n_cmp = 0, n_bad = 0, k = 0;
  logic [15:0] m_sh = 0;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DL), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .thou(thou), .hund(hund), .ten(ten), .one(one),
    .load(load), .dp(dp), .blink_mask(blink_mask), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp_out(dp_out), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask
  function automatic logic [11:0] model(input int kk, input logic [15:0] sh, input logic [3:0] dpv,
                                        input logic [3:0] bm, input logic blz);
    int i = (kk / SD) % 4;
    logic [3:0] d = sh[i*4 +: 4];
    if (kk % SD < DL || (((kk / BD) % 2) == 1 && bm[i])) return {4'hf, 7'h7f, 1'b1};
    return {~(4'b1 << i), (i > 0 && blz && (sh >> (i * 4)) == 16'h0) ? 7'h7f :
            d > 9 ? 7'b0111111 : pat[d], ~dpv[i]};
  endfunction
  task automatic cyc();
    logic [11:0] e = model(k, m_sh, dp, blink_mask, blank_lz);
    logic ef = ((k + 1) % (4 * SD)) == 0;
    @(posedge clk);
    if (load) m_sh = {thou, hund, ten, one};
    k++;
    @(negedge clk);
    chk("an", an, e[11:8]);
    chk("seg", seg, e[7:1]);
    chk("dp_out", dp_out, e[0]);
    chk("frame_tick", frame_tick, ef);
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic ld(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    {thou, hund, ten, one} = {a, b, c, d};
    load = 1;
    cyc();
    load = 0;
  endtask
  task automatic reset_mid();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_ft", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1;
    k = 0;
    m_sh = 0;
  endtask
  initial begin
    #12;
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_ft", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1;
    ld(1, 2, 3, 4);
    chk("dead_an", an, 4'hf);
    cyc();
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b0011001);
    run(40);
    blank_lz = 1;
    ld(0, 0, 0, 7);
    run(20);
    ld(0, 0, 0, 0);
    run(20);
    blank_lz = 0;
    dp = 4'b0100;
    ld(1, 2, 4'hc, 3);
    run(20);
    dp = 0;
    blink_mask = 4'b0001;
    run(80);
    repeat (800) begin
      load = $urandom_range(0, 4) == 0;
      thou = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
      hund = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
      ten  = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
      one  = 4'($urandom_range(0, 15));
      dp = 4'($urandom);
      blink_mask = 4'($urandom);
      blank_lz = 1'($urandom);
      cyc();
    end
    load = 0;
    dp = 0;
    blink_mask = 0;
    run(6);
    reset_mid();
    ld(0, 0, 0, 5);
    cyc();
    chk("mid5_seg", seg, 7'b0010010);
    ld(0, 0, 0, 9);
    chk("mid5_hold", seg, 7'b0010010);
    cyc();
    chk("mid9_seg", seg, 7'b0010000);
    run(30);
    run(3);
    reset_mid();
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
